// File: rtl/memory_arbiter_if.sv
// Bundle of fetch, MEM-stage and memory-side signals shared by the arbiter and its environment.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                  instrRequest;
    logic [ADDR_WIDTH-1:0] instrAddress;
    logic [DATA_WIDTH-1:0] instrReadData;
    logic                  instrDone;
    logic                  isInstructionMemoryBlocked;

    logic                  dataRequest;
    logic                  dataWriteEnable;
    logic [ADDR_WIDTH-1:0] dataAddress;
    logic [DATA_WIDTH-1:0] dataWriteData;
    logic [MASK_WIDTH-1:0] dataWriteMask;
    logic [DATA_WIDTH-1:0] dataReadData;
    logic                  dataDone;
    logic                  isDataMemoryBlocked;

    logic                  memRequest;
    logic                  memWriteEnable;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic [MASK_WIDTH-1:0] memWriteMask;
    logic [DATA_WIDTH-1:0] memReadData;
    logic                  memReady;
    logic                  memTimeoutError;

    modport slave (
        input  instrRequest, instrAddress,
        output instrReadData, instrDone, isInstructionMemoryBlocked,
        input  dataRequest, dataWriteEnable, dataAddress, dataWriteData, dataWriteMask,
        output dataReadData, dataDone, isDataMemoryBlocked,
        output memRequest, memWriteEnable, memAddress, memWriteData, memWriteMask,
        input  memReadData, memReady,
        output memTimeoutError
    );

    modport master (
        output instrRequest, instrAddress,
        input  instrReadData, instrDone, isInstructionMemoryBlocked,
        output dataRequest, dataWriteEnable, dataAddress, dataWriteData, dataWriteMask,
        input  dataReadData, dataDone, isDataMemoryBlocked,
        input  memRequest, memWriteEnable, memAddress, memWriteData, memWriteMask,
        output memReadData, memReady,
        input  memTimeoutError
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and the MEM stage.
// Data has fixed priority; fetches whose PC moved on while in flight complete silently.
module memory_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             reset,
    memory_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_DATA,
        BUSY_INSTR,
        RESPOND
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] waitCount;
    logic             timeoutNow;
    logic             instrStale;

    // Abort on the wait cycle that brings the counter up to TIMEOUT_CYCLES.
    assign timeoutNow = !bus.memReady && (waitCount == LAST_WAIT);
    assign instrStale = !bus.instrRequest || (bus.instrAddress != bus.memAddress);

    assign bus.isInstructionMemoryBlocked = bus.instrRequest && !bus.instrDone;
    assign bus.isDataMemoryBlocked        = bus.dataRequest && !bus.dataDone;

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            waitCount           <= '0;
            bus.memRequest      <= 1'b0;
            bus.memWriteEnable  <= 1'b0;
            bus.memAddress      <= '0;
            bus.memWriteData    <= '0;
            bus.memWriteMask    <= '0;
            bus.instrReadData   <= '0;
            bus.dataReadData    <= '0;
            bus.instrDone       <= 1'b0;
            bus.dataDone        <= 1'b0;
            bus.memTimeoutError <= 1'b0;
        end else begin
            bus.instrDone <= 1'b0;
            bus.dataDone  <= 1'b0;
            case (state)
                IDLE: begin
                    waitCount <= '0;
                    if (bus.dataRequest) begin
                        bus.memRequest     <= 1'b1;
                        bus.memWriteEnable <= bus.dataWriteEnable;
                        bus.memAddress     <= bus.dataAddress;
                        bus.memWriteData   <= bus.dataWriteData;
                        bus.memWriteMask   <= bus.dataWriteMask;
                        state              <= BUSY_DATA;
                    end else if (bus.instrRequest) begin
                        bus.memRequest     <= 1'b1;
                        bus.memWriteEnable <= 1'b0;
                        bus.memAddress     <= bus.instrAddress;
                        bus.memWriteData   <= '0;
                        bus.memWriteMask   <= '0;
                        state              <= BUSY_INSTR;
                    end
                end

                BUSY_DATA: begin
                    if (!bus.memReady) waitCount <= waitCount + 1'b1;
                    if (bus.memReady || timeoutNow) begin
                        bus.memRequest   <= 1'b0;
                        bus.dataDone     <= 1'b1;
                        bus.dataReadData <= (bus.memReady && !bus.memWriteEnable) ? bus.memReadData : '0;
                        if (timeoutNow) bus.memTimeoutError <= 1'b1;
                        state <= RESPOND;
                    end
                end

                BUSY_INSTR: begin
                    if (!bus.memReady) waitCount <= waitCount + 1'b1;
                    if (bus.memReady || timeoutNow) begin
                        bus.memRequest <= 1'b0;
                        if (timeoutNow) bus.memTimeoutError <= 1'b1;
                        // A redirected or withdrawn fetch leaves instrReadData untouched.
                        if (!instrStale) begin
                            bus.instrDone     <= 1'b1;
                            bus.instrReadData <= bus.memReady ? bus.memReadData : '0;
                        end
                        state <= RESPOND;
                    end
                end

                RESPOND: begin
                    waitCount <= '0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a latency-programmable memory responder plus a
// scoreboard of expected completions popped whenever instrDone or dataDone pulses.
module tb_memory_arbiter;
    logic clk;
    logic reset;

    memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    memory_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit          isData;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   memLatency = 1;
    bit   memEnable  = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'hC0DE_0000) + 32'h11);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic waitDone(input bit isData, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            tick();
            seen = isData ? bus.dataDone : bus.instrDone;
        end
        check(isData ? "dataDone_in_budget" : "instrDone_in_budget", {63'd0, seen}, 64'd1);
    endtask

    // Memory model: memReady in the memLatency-th cycle that memRequest is high.
    initial begin
        int waitCnt;
        waitCnt          = 0;
        bus.memReady     = 1'b0;
        bus.memReadData  = '0;
        forever begin
            @(negedge clk);
            if (bus.memRequest && memEnable) begin
                waitCnt++;
                if (waitCnt >= memLatency) begin
                    bus.memReady    = 1'b1;
                    bus.memReadData = memFn(bus.memAddress);
                end else begin
                    bus.memReady = 1'b0;
                end
            end else begin
                waitCnt      = 0;
                bus.memReady = 1'b0;
            end
        end
    end

    // Completion monitor, pulse-width and latched-field stability checks.
    initial begin
        exp_t        e;
        logic        prevReq = 1'b0;
        logic        prevInstrDone = 1'b0;
        logic        prevDataDone = 1'b0;
        logic [63:0] prevFields = '0;
        logic [63:0] fields;
        forever begin
            @(negedge clk);
            fields = {27'd0, bus.memWriteEnable, bus.memWriteMask, bus.memAddress};
            if (bus.memRequest && prevReq) check("mem_fields_stable", fields, prevFields);
            if (bus.instrDone || bus.dataDone) begin
                check("done_exclusive", {63'd0, bus.instrDone & bus.dataDone}, 64'd0);
                check("done_one_cycle", {63'd0, (bus.instrDone & prevInstrDone) | (bus.dataDone & prevDataDone)}, 64'd0);
                check("sb_nonempty", {63'd0, sbq.size() != 0}, 64'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("sb_requester", {63'd0, bus.dataDone}, {63'd0, e.isData});
                    check("sb_data", {32'd0, bus.dataDone ? bus.dataReadData : bus.instrReadData}, {32'd0, e.data});
                end
            end
            prevReq       = bus.memRequest;
            prevFields    = fields;
            prevInstrDone = bus.instrDone;
            prevDataDone  = bus.dataDone;
        end
    end

    initial begin
        logic expReq1[5]  = '{1, 1, 1, 0, 0};
        logic expDone1[5] = '{0, 0, 0, 1, 0};
        reset               = 1'b1;
        bus.instrRequest    = 1'b0;
        bus.instrAddress    = '0;
        bus.dataRequest     = 1'b0;
        bus.dataWriteEnable = 1'b0;
        bus.dataAddress     = '0;
        bus.dataWriteData   = '0;
        bus.dataWriteMask   = '0;
        repeat (3) tick();

        // Reset state
        check("rst_memRequest", {63'd0, bus.memRequest}, 64'd0);
        check("rst_memAddress", {32'd0, bus.memAddress}, 64'd0);
        check("rst_dones", {62'd0, bus.instrDone, bus.dataDone}, 64'd0);
        check("rst_timeoutError", {63'd0, bus.memTimeoutError}, 64'd0);
        check("rst_blocked", {62'd0, bus.isInstructionMemoryBlocked, bus.isDataMemoryBlocked}, 64'd0);
        reset = 1'b0;
        tick();

        // Fetch 0x100, memReady three cycles after grant
        memLatency       = 3;
        bus.instrRequest = 1'b1;
        bus.instrAddress = 32'h100;
        sbq.push_back('{1'b0, 32'hDEADBEEF});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("f1_memRequest", {63'd0, bus.memRequest}, {63'd0, expReq1[i]});
            check("f1_instrDone", {63'd0, bus.instrDone}, {63'd0, expDone1[i]});
            if (i == 0) begin
                check("f1_memAddress", {32'd0, bus.memAddress}, 64'h100);
                check("f1_memWriteEnable", {63'd0, bus.memWriteEnable}, 64'd0);
                check("f1_blocked", {63'd0, bus.isInstructionMemoryBlocked}, 64'd1);
            end
            if (i == 3) begin
                check("f1_unblocked", {63'd0, bus.isInstructionMemoryBlocked}, 64'd0);
                bus.instrRequest = 1'b0;
            end
        end

        // Simultaneous fetch and store: store first, fetch granted three cycles later
        memLatency          = 1;
        bus.instrRequest    = 1'b1;
        bus.instrAddress    = 32'h104;
        bus.dataRequest     = 1'b1;
        bus.dataWriteEnable = 1'b1;
        bus.dataAddress     = 32'h200;
        bus.dataWriteData   = 32'h55AA;
        bus.dataWriteMask   = 4'b0011;
        sbq.push_back('{1'b1, 32'h0});
        sbq.push_back('{1'b0, memFn(32'h104)});
        tick();
        check("pr_memRequest", {63'd0, bus.memRequest}, 64'd1);
        check("pr_memAddress", {32'd0, bus.memAddress}, 64'h200);
        check("pr_memWrite", {27'd0, bus.memWriteEnable, bus.memWriteMask, bus.memWriteData}, {27'd0, 1'b1, 4'b0011, 32'h55AA});
        tick();
        check("pr_dataDone", {63'd0, bus.dataDone}, 64'd1);
        check("pr_memRequest_drop", {63'd0, bus.memRequest}, 64'd0);
        bus.dataRequest = 1'b0;
        tick();
        check("pr_respond_noGrant", {63'd0, bus.memRequest}, 64'd0);
        tick();
        check("pr_fetchGrant", {63'd0, bus.memRequest}, 64'd1);
        check("pr_fetchAddr", {32'd0, bus.memAddress}, 64'h104);
        check("pr_fetchMask", {59'd0, bus.memWriteEnable, bus.memWriteMask}, 64'd0);
        waitDone(1'b0, 6);
        bus.instrRequest = 1'b0;
        tick();

        // Stale fetch: PC redirected from 0x100 to 0x180 while in flight
        memLatency       = 3;
        bus.instrRequest = 1'b1;
        bus.instrAddress = 32'h100;
        tick();
        check("st_memAddress", {32'd0, bus.memAddress}, 64'h100);
        tick();
        bus.instrAddress = 32'h180;
        sbq.push_back('{1'b0, memFn(32'h180)});
        tick();
        check("st_addrHeld", {32'd0, bus.memAddress}, 64'h100);
        tick();
        check("st_noDone", {63'd0, bus.instrDone}, 64'd0);
        check("st_memRequest_drop", {63'd0, bus.memRequest}, 64'd0);
        tick();
        check("st_respond", {63'd0, bus.memRequest}, 64'd0);
        tick();
        check("st_regrant", {63'd0, bus.memRequest}, 64'd1);
        check("st_newAddr", {32'd0, bus.memAddress}, 64'h180);
        waitDone(1'b0, 8);
        bus.instrRequest = 1'b0;
        tick();

        // Back-to-back loads 0x10 / 0x14 with immediate memReady
        memLatency          = 1;
        bus.dataRequest     = 1'b1;
        bus.dataWriteEnable = 1'b0;
        bus.dataAddress     = 32'h10;
        sbq.push_back('{1'b1, memFn(32'h10)});
        tick();
        check("bb_grant1", {32'd0, bus.memRequest, bus.memAddress}, {32'd1, 32'h10});
        tick();
        check("bb_done1", {63'd0, bus.dataDone}, 64'd1);
        bus.dataAddress = 32'h14;
        sbq.push_back('{1'b1, memFn(32'h14)});
        tick();
        check("bb_pulse1", {62'd0, bus.dataDone, bus.memRequest}, 64'd0);
        tick();
        check("bb_grant2", {32'd0, bus.memRequest, bus.memAddress}, {32'd1, 32'h14});
        tick();
        check("bb_done2", {63'd0, bus.dataDone}, 64'd1);
        bus.dataRequest = 1'b0;
        tick();
        check("bb_pulse2", {63'd0, bus.dataDone}, 64'd0);

        // Timeout: memory never answers
        memEnable       = 1'b0;
        bus.dataRequest = 1'b1;
        bus.dataAddress = 32'h300;
        sbq.push_back('{1'b1, 32'h0});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("to_memRequest", {63'd0, bus.memRequest}, (i < 4) ? 64'd1 : 64'd0);
        end
        check("to_dataDone", {63'd0, bus.dataDone}, 64'd1);
        check("to_error", {63'd0, bus.memTimeoutError}, 64'd1);
        bus.dataRequest = 1'b0;
        repeat (3) tick();
        check("to_error_sticky", {63'd0, bus.memTimeoutError}, 64'd1);

        // Reset in BUSY_DATA
        bus.dataRequest = 1'b1;
        bus.dataAddress = 32'h400;
        tick();
        check("rb_busy", {63'd0, bus.memRequest}, 64'd1);
        reset           = 1'b1;
        bus.dataRequest = 1'b0;
        tick();
        check("rb_memRequest", {63'd0, bus.memRequest}, 64'd0);
        check("rb_noDone", {63'd0, bus.dataDone}, 64'd0);
        check("rb_errorCleared", {63'd0, bus.memTimeoutError}, 64'd0);
        reset     = 1'b0;
        memEnable = 1'b1;
        tick();
        check("rb_idle", {62'd0, bus.memRequest, bus.dataDone}, 64'd0);
        repeat (2) tick();

        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
